// File: rtl/gpu_pkg.sv
// Shared GPU front-end types: default array sizing, dispatcher state encoding
// and a saturating counter helper.
package gpu_pkg;

  localparam int NUM_PBS_DEFAULT = 8;
  localparam int IDX_W_DEFAULT   = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } dispatch_state_t;

  typedef logic [IDX_W_DEFAULT-1:0] block_idx_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/lowest_free_arbiter.sv
// Fixed-priority picker: one-hot grant of the lowest-numbered free slot.
module lowest_free_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_free,
  output logic [N-1:0] o_grant,
  output logic         o_valid
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_grant = i_free & (~i_free + N'(1));
  assign o_valid = |i_free;

endmodule

// File: rtl/block_dispatcher.sv
// Dynamic thread-block dispatcher: hands block indices to processing blocks as each frees up.
// Define BLOCK_DISPATCHER_STATS_EN to add busy-cycle and completed-block counters.
module block_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_PBS = NUM_PBS_DEFAULT,
  parameter int IDX_W   = IDX_W_DEFAULT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            launch_valid,
  output logic                            launch_ready,
  input  logic [IDX_W-1:0]                launch_blocks,
  output logic [NUM_PBS-1:0]              pb_start,
  output logic [NUM_PBS-1:0][IDX_W-1:0]   pb_block_idx,
  input  logic [NUM_PBS-1:0]              pb_finished,
  output logic                            busy,
  output logic                            kernel_done
`ifdef BLOCK_DISPATCHER_STATS_EN
  ,
  output logic [31:0]                     stat_busy_cycles,
  output logic [31:0]                     stat_blocks_done
`endif
);

  dispatch_state_t r_state, w_nextState;
  logic [IDX_W-1:0]              r_total, r_nextIdx;
  logic [NUM_PBS-1:0]            r_running, r_start, r_startD1;
  logic [NUM_PBS-1:0][IDX_W-1:0] r_blockIdx;

  logic               w_accept, w_dispatch, w_grantValid;
  logic [NUM_PBS-1:0] w_grant, w_startVec, w_clear, w_remaining;
  logic [IDX_W-1:0]   w_dispIdx, w_target, w_idxPlus;

  assign w_accept = (r_state == S_IDLE) && launch_valid;

  // A finished level seen within two cycles of a start is left over from the previous block.
  assign w_clear     = r_running & pb_finished & ~r_start & ~r_startD1;
  assign w_remaining = r_running & ~w_clear;

  // The first start is issued on the accept edge itself, so IDLE dispatches from index 0.
  assign w_dispIdx  = (r_state == S_IDLE) ? '0 : r_nextIdx;
  assign w_target   = (r_state == S_IDLE) ? launch_blocks : r_total;
  assign w_idxPlus  = w_dispIdx + IDX_W'(1);
  assign w_startVec = w_dispatch ? w_grant : '0;

  lowest_free_arbiter #(.N(NUM_PBS)) u_arbiter (
    .i_free  (~r_running),
    .o_grant (w_grant),
    .o_valid (w_grantValid)
  );

  always_comb begin
    w_nextState = r_state;
    w_dispatch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (launch_valid) begin
          if (launch_blocks == '0) begin
            w_nextState = S_DONE;
          end else begin
            w_dispatch  = w_grantValid;
            w_nextState = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: w_dispatch = w_grantValid;
      S_DRAIN:    if (w_remaining == '0) w_nextState = S_DONE;
      S_DONE:     w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
    if (w_dispatch && (w_idxPlus == w_target)) w_nextState = S_DRAIN;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_total    <= '0;
      r_nextIdx  <= '0;
      r_running  <= '0;
      r_start    <= '0;
      r_startD1  <= '0;
      r_blockIdx <= '0;
    end else begin
      r_state   <= w_nextState;
      r_running <= w_remaining | w_startVec;
      r_start   <= w_startVec;
      r_startD1 <= r_start;
      if (w_accept) r_total <= launch_blocks;
      if (w_dispatch) r_nextIdx <= w_idxPlus;
      else if (w_accept) r_nextIdx <= '0;
      for (int i = 0; i < NUM_PBS; i++) begin
        if (w_startVec[i]) r_blockIdx[i] <= w_dispIdx;
      end
    end
  end

  assign launch_ready = (r_state == S_IDLE);
  assign busy         = (r_state == S_DISPATCH) || (r_state == S_DRAIN);
  assign kernel_done  = (r_state == S_DONE);
  assign pb_start     = r_start;
  assign pb_block_idx = r_blockIdx;

`ifdef BLOCK_DISPATCHER_STATS_EN
  logic [31:0] r_statBusy, r_statDone;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_statBusy <= '0;
      r_statDone <= '0;
    end else if (w_accept) begin
      r_statBusy <= '0;
      r_statDone <= '0;
    end else begin
      if (busy) r_statBusy <= sat_add32(r_statBusy, 32'd1);
      r_statDone <= sat_add32(r_statDone, 32'($countones(w_clear)));
    end
  end

  assign stat_busy_cycles = r_statBusy;
  assign stat_blocks_done = r_statDone;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Scoreboard bench for block_dispatcher: expected indices are queued at launch and
// popped as pb_start pulses appear; PB models finish after per-slot latencies.
module tb_block_dispatcher;
  import gpu_pkg::*;

  localparam int NPB = NUM_PBS_DEFAULT;
  localparam int IW  = IDX_W_DEFAULT;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     launch_valid, launch_ready;
  logic [IW-1:0]            launch_blocks;
  logic [NPB-1:0]           pb_start;
  logic [NPB-1:0]           pb_finished = '0;
  logic [NPB-1:0][IW-1:0]   pb_block_idx;
  logic                     busy, kernel_done;
`ifdef BLOCK_DISPATCHER_STATS_EN
  logic [31:0]              stat_busy_cycles, stat_blocks_done;
`endif

  int vectorsApplied = 0;
  int miscompares    = 0;
  int cycleCount     = 0;
  int expQ[$];
  int lat[NPB];
  int rem[NPB];
  bit holdHigh = 1'b0;
  int startPb[64];
  int startAbs[64];
  int lastStartAbs[NPB];
  bit hasStarted[NPB];
  int acceptAbs;
  int doneCount;
  int relDone;

  block_dispatcher dut (
    .clock         (clock),
    .reset         (reset),
    .launch_valid  (launch_valid),
    .launch_ready  (launch_ready),
    .launch_blocks (launch_blocks),
    .pb_start      (pb_start),
    .pb_block_idx  (pb_block_idx),
    .pb_finished   (pb_finished),
    .busy          (busy),
    .kernel_done   (kernel_done)
`ifdef BLOCK_DISPATCHER_STATS_EN
    ,
    .stat_busy_cycles (stat_busy_cycles),
    .stat_blocks_done (stat_blocks_done)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycleCount++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // PB model: finished level rises lat cycles after start and stays high until the next start.
  always @(negedge clock) begin
    for (int i = 0; i < NPB; i++) begin
      if (holdHigh) begin
        pb_finished[i] = 1'b1;
        rem[i] = 0;
      end else if (reset) begin
        pb_finished[i] = 1'b0;
        rem[i] = 0;
      end else if (pb_start[i]) begin
        rem[i] = lat[i];
      end else if (rem[i] > 0) begin
        rem[i]--;
        pb_finished[i] = (rem[i] == 0);
      end
    end
  end

  always @(negedge clock) begin
    int e;
    if (!reset) begin
      if (pb_start != '0) checkOutput("one_start_per_cycle", 32'($countones(pb_start)), 1);
      for (int i = 0; i < NPB; i++) begin
        if (pb_start[i]) begin
          checkOutput("start_expected", 32'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("block_idx", 32'(pb_block_idx[i]), e);
            if (e < 64) begin
              startPb[e]  = i;
              startAbs[e] = cycleCount;
            end
          end
          if (hasStarted[i]) checkOutput("restart_gap", 32'((cycleCount - lastStartAbs[i]) >= 3), 1);
          hasStarted[i]   = 1'b1;
          lastStartAbs[i] = cycleCount;
        end
      end
      if (kernel_done) doneCount++;
    end
  end

  task automatic applyStimulus(input int n);
    int guard = 0;
    while (!launch_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("launch_ready", 32'(launch_ready), 1);
    for (int i = 0; i < n; i++) expQ.push_back(i);
    for (int i = 0; i < NPB; i++) hasStarted[i] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      startPb[i]  = -1;
      startAbs[i] = -1;
    end
    doneCount     = 0;
    launch_valid  = 1'b1;
    launch_blocks = IW'(n);
    @(negedge clock);
    acceptAbs     = cycleCount;
    launch_valid  = 1'b0;
    launch_blocks = IW'($urandom);
  endtask

  task automatic waitDone(input int budget, output int rel);
    int n = 0;
    while (!kernel_done && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("kernel_done_seen", 32'(kernel_done), 1);
    rel = cycleCount - acceptAbs + 1;
  endtask

  task automatic checkEnd(input string tag);
    @(negedge clock);
    checkOutput({tag, "_done_pulse"}, 32'(kernel_done), 0);
    checkOutput({tag, "_ready_after"}, 32'(launch_ready), 1);
    @(negedge clock);
    checkOutput({tag, "_queue_empty"}, 32'(expQ.size()), 0);
    checkOutput({tag, "_done_count"}, 32'(doneCount), 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(launch_ready), 1);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(kernel_done), 0);
    checkOutput({tag, "_start"}, 32'(pb_start), 0);
    checkOutput({tag, "_idx_zero"}, 32'(pb_block_idx == '0), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    launch_valid = 1'b0;
    launch_blocks = '0;
    for (int i = 0; i < NPB; i++) lat[i] = 8;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkResetValues("reset");

    // All slots free: PB i gets idx i in cycle i+1; last finish in cycle 16 -> done in cycle 17.
    applyStimulus(8);
    checkOutput("t1_busy", 32'(busy), 1);
    waitDone(100, relDone);
    checkOutput("t1_done_cycle", relDone, 17);
    checkOutput("t1_not_ready_at_done", 32'(launch_ready), 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t1_start_pb", startPb[i], i);
      checkOutput("t1_start_cycle", startAbs[i] - acceptAbs + 1, i + 1);
    end
    checkEnd("t1");

    // PB3 is fastest and must pick up idx 8; a stray launch while busy is ignored.
    for (int i = 0; i < NPB; i++) lat[i] = 12;
    lat[3] = 3;
    applyStimulus(20);
    repeat (3) @(negedge clock);
    launch_valid  = 1'b1;
    launch_blocks = IW'(5);
    @(negedge clock);
    launch_valid  = 1'b0;
    waitDone(400, relDone);
    for (int i = 0; i < 8; i++) checkOutput("t2_start_pb", startPb[i], i);
    checkOutput("t2_pb3_gets_idx8", startPb[8], 3);
    checkEnd("t2");

    // Empty launch completes in cycle 1 with no starts.
    applyStimulus(0);
    waitDone(10, relDone);
    checkOutput("t3_done_cycle", relDone, 1);
    checkEnd("t3");

    // Finished held high throughout: blanking must still yield exactly 12 starts.
    holdHigh = 1'b1;
    @(negedge clock);
    applyStimulus(12);
    waitDone(400, relDone);
    checkEnd("t4");
    holdHigh = 1'b0;

    // Reset mid-dispatch after three starts, then relaunch from idx 0.
    for (int i = 0; i < NPB; i++) lat[i] = 30;
    applyStimulus(40);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkResetValues("midreset");
    checkOutput("midreset_issued", 32'(40 - expQ.size()), 3);
    expQ.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NPB; i++) lat[i] = 4;
    applyStimulus(4);
    waitDone(100, relDone);
    checkOutput("t5_idx0_pb", startPb[0], 0);
    checkOutput("t5_idx0_cycle", startAbs[0] - acceptAbs + 1, 1);
    checkEnd("t5");

`ifdef BLOCK_DISPATCHER_STATS_EN
    begin
      int busyCount = 0;
      int n = 0;
      for (int i = 0; i < NPB; i++) lat[i] = 3 + (i % 4);
      applyStimulus(12);
      while (!kernel_done && n < 400) begin
        if (busy) busyCount++;
        @(negedge clock);
        n++;
      end
      checkOutput("stats_done_seen", 32'(kernel_done), 1);
      repeat (2) @(negedge clock);
      checkOutput("stat_blocks_done", stat_blocks_done, 12);
      checkOutput("stat_busy_cycles", stat_busy_cycles, busyCount);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
